// File: rtl/buf_frame_reader.sv
// buf_frame_reader: drains one line-buffer bank into header-framed valid/ready words.
// Define BUF_FRAME_CHECKSUM_EN to append an XOR trailer word to every frame.
module buf_frame_reader #(
    parameter int DW          = 32,
    parameter int AW          = 6,
    parameter int MAXPERFRAME = 184,
    parameter int FIFO_AW     = 2
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_start,
    input  logic          i_readable,
    output logic          o_rd_en,
    input  logic          i_rd_dv,
    input  logic [DW-1:0] i_rd_data,
    output logic [DW-1:0] o_out_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic          o_out_sof,
    output logic          o_out_eof,
    output logic          o_busy,
    output logic [15:0]   o_seq
);
    localparam int CW = (AW + 1 > 17) ? AW + 1 : 17;
    localparam int SW = FIFO_AW + 2;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [CW-1:0] NW_C = CW'(2 ** AW);
    localparam logic [CW-1:0] MAXF_C = CW'(MAXPERFRAME);
    localparam logic [SW-1:0] DEPTH_C = SW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DRAIN} state_t;
    state_t r_state, w_next;

    logic [CW-1:0]      r_left, r_n, r_issued, r_rcv, w_n, w_left_nx;
    logic [FIFO_AW:0]   r_outstanding, r_fifo_cnt;
    logic [FIFO_AW-1:0] r_wp, r_rp;
    logic [DW+1:0]      r_mem [DEPTH];
    logic [DW+1:0]      w_din, w_head;
    logic [DW-1:0]      w_trl_data;
    logic [15:0]        r_seq;
    logic w_dv, w_full, w_pop, w_push, w_hdr_push, w_hdr_go, w_credit;
    logic w_last, w_last_eof, w_trl, w_trl_push, w_frame_done;

    assign w_n          = (r_left > MAXF_C) ? MAXF_C : r_left;
    assign w_left_nx    = r_left - r_n;
    assign w_dv         = i_rd_dv && (r_state != S_IDLE);
    assign w_full       = {1'b0, r_fifo_cnt} == DEPTH_C;
    assign w_credit     = ({1'b0, r_fifo_cnt} + {1'b0, r_outstanding}) < DEPTH_C;
    assign w_pop        = o_out_valid && i_out_ready;
    assign w_last       = w_dv && (r_rcv == r_n - 1'b1);
    assign w_frame_done = r_issued == r_n;
    assign w_hdr_go     = (r_outstanding == '0) && !w_full && !w_trl;

    always_ff @(posedge i_clk)
        r_state <= !i_reset_n ? S_IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start && i_readable) w_next = S_HDR;
            S_HDR:   if (w_hdr_go) w_next = S_DATA;
            S_DATA:  if (w_frame_done) w_next = (w_left_nx != '0) ? S_HDR : S_DRAIN;
            S_DRAIN: if (r_outstanding == '0 && r_fifo_cnt == '0 && !w_trl) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_rd_en    = (r_state == S_DATA) && (r_issued < r_n) && w_credit;
        o_busy     = r_state != S_IDLE;
        w_hdr_push = (r_state == S_HDR) && w_hdr_go;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_left        <= '0;
            r_n           <= '0;
            r_issued      <= '0;
            r_rcv         <= '0;
            r_seq         <= '0;
            r_outstanding <= '0;
        end else begin
            if (r_state == S_IDLE && i_start && i_readable) r_left <= NW_C;
            if (r_state == S_DATA && w_frame_done) r_left <= w_left_nx;
            if (w_hdr_push) begin
                r_n      <= w_n;
                r_issued <= '0;
                r_rcv    <= '0;
                r_seq    <= r_seq + 1'b1;
            end else begin
                if (o_rd_en) r_issued <= r_issued + 1'b1;
                if (w_dv) r_rcv <= r_rcv + 1'b1;
            end
            r_outstanding <= r_outstanding + (FIFO_AW+1)'(o_rd_en) - (FIFO_AW+1)'(w_dv);
        end
    end

`ifdef BUF_FRAME_CHECKSUM_EN
    logic          r_trl;
    logic [DW-1:0] r_xor;
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_trl <= 1'b0;
            r_xor <= '0;
        end else begin
            if (w_hdr_push) r_xor <= '0;
            else if (w_dv) r_xor <= r_xor ^ i_rd_data;
            if (w_last) r_trl <= 1'b1;
            else if (w_trl_push) r_trl <= 1'b0;
        end
    end
    assign w_trl      = r_trl;
    assign w_trl_push = r_trl && !w_full;
    assign w_trl_data = r_xor;
    assign w_last_eof = 1'b0;
`else
    assign w_trl      = 1'b0;
    assign w_trl_push = 1'b0;
    assign w_trl_data = '0;
    assign w_last_eof = w_last;
`endif

    // Header, trailer and returned data never coincide, so a priority mux is enough.
    assign w_push = w_hdr_push || w_dv || w_trl_push;
    assign w_din  = w_hdr_push ? {2'b10, DW'({r_seq, w_n[15:0]})} :
                    w_trl_push ? {2'b01, w_trl_data} : {1'b0, w_last_eof, i_rd_data};

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_fifo_cnt <= r_fifo_cnt + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);
        end
    end

    always_ff @(posedge i_clk)
        if (w_push) r_mem[r_wp] <= w_din;

    assign w_head      = r_mem[r_rp];
    assign o_out_valid = r_fifo_cnt != '0;
    assign o_out_sof   = o_out_valid && w_head[DW+1];
    assign o_out_eof   = o_out_valid && w_head[DW];
    assign o_out_data  = w_head[DW-1:0];
    assign o_seq       = r_seq;
endmodule

// File: tb/tb_buf_frame_reader.sv
// tb_buf_frame_reader: scoreboarded bank drains over latency/backpressure variants,
// plus ignored starts and a mid-bank reset with reads still in flight.
module tb_buf_frame_reader;
`ifdef BUF_FRAME_CHECKSUM_EN
    localparam int MAXF = 64;
    localparam bit CK = 1'b1;
`else
    localparam int MAXF = 24;
    localparam bit CK = 1'b0;
`endif
    localparam int NW = 64;
    localparam int NFR = (NW + MAXF - 1) / MAXF;
    localparam int NWORDS = NW + NFR * (CK ? 2 : 1);

    logic        clk = 1'b0;
    logic        reset_n, start, readable, rd_en, rd_dv, out_valid, out_sof, out_eof, busy, m_clr;
    logic        out_ready = 1'b1;
    logic [31:0] rd_data, out_data, m_addr;
    logic [15:0] seq, exp_seq;
    logic [3:0]  dv_sr;
    logic [31:0] d_sr [4];
    logic [33:0] exp_q [$];
    logic [33:0] e;
    int lat = 2, duty_g = 100, rd_cnt = 0, n_vec = 0, n_err = 0, pay_pops = 0, tot_pops = 0, mon_viol = 0;

    typedef struct {
        int lat;
        int duty;
        bit restart;
        int exp_words;
        int exp_frames;
    } vec_t;
    vec_t tbl [5];

    buf_frame_reader #(.DW(32), .AW(6), .MAXPERFRAME(MAXF), .FIFO_AW(2)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_readable(readable),
        .o_rd_en(rd_en), .i_rd_dv(rd_dv), .i_rd_data(rd_data),
        .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_sof(out_sof), .o_out_eof(out_eof), .o_busy(busy), .o_seq(seq)
    );

    always #5 clk = ~clk;

    // Line-buffer read port: data = address, returned lat cycles after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_cnt <= rd_cnt + 1;
        if (m_clr) begin
            dv_sr  <= '0;
            m_addr <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                dv_sr[k] <= dv_sr[k+1];
                d_sr[k]  <= d_sr[k+1];
            end
            dv_sr[3] <= 1'b0;
            if (rd_en) begin
                dv_sr[lat-1] <= 1'b1;
                d_sr[lat-1]  <= m_addr;
                m_addr       <= m_addr + 1;
            end
        end
    end
    assign rd_dv   = dv_sr[0];
    assign rd_data = d_sr[0];

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = (duty_g >= 100) || ($urandom_range(0, 99) < duty_g);
    end

    always @(negedge clk) begin
        if (reset_n && ((dut.r_fifo_cnt + dut.r_outstanding > 4) ||
            (rd_en && dut.r_fifo_cnt + dut.r_outstanding >= 4))) mon_viol++;
        if (out_valid && out_ready) begin
            n_vec++;
            tot_pops++;
            if (!out_sof) pay_pops++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL extra_word: got sof=%0b eof=%0b data=%h, required no word", out_sof, out_eof, out_data);
            end else begin
                e = exp_q.pop_front();
                if ({out_sof, out_eof, out_data} !== e) begin
                    n_err++;
                    $display("FAIL word: got sof=%0b eof=%0b data=%h, required sof=%0b eof=%0b data=%h",
                             out_sof, out_eof, out_data, e[33], e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic gen_exp(input logic [15:0] s);
        int left = NW;
        int a = 0;
        logic [31:0] x;
        while (left > 0) begin
            int n;
            n = (left > MAXF) ? MAXF : left;
            exp_q.push_back({2'b10, s, 16'(n)});
            x = '0;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({1'b0, !CK && (i == n - 1), 32'(a)});
                x = x ^ 32'(a);
                a++;
            end
            if (CK) exp_q.push_back({2'b01, x});
            left -= n;
            s++;
        end
    endtask

    task automatic run_bank(input vec_t v);
        int t = 0;
        int rd0, p0;
        lat = v.lat;
        duty_g = v.duty;
        m_clr = 1'b1;
        tick();
        m_clr = 1'b0;
        gen_exp(exp_seq);
        rd0 = rd_cnt;
        p0 = tot_pops;
        mon_viol = 0;
        start = 1'b1;
        readable = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 1);
        while (busy && t < 3000) begin
            if (v.restart && t == 20) start = 1'b1;
            tick();
            start = 1'b0;
            t++;
        end
        check("bank_done", {31'b0, t < 3000}, 1);
        check("queue_drained", exp_q.size(), 0);
        check("word_count", tot_pops - p0, v.exp_words);
        exp_seq = exp_seq + 16'(v.exp_frames);
        check("seq", {16'b0, seq}, {16'b0, exp_seq});
        check("rd_en_count", rd_cnt - rd0, NW);
        check("credit_viol", mon_viol, 0);
        duty_g = 100;
        tick(10);
        check("idle_stays", {31'b0, busy}, 0);
        check("no_extra_reads", rd_cnt - rd0, NW);
        exp_q.delete();
    endtask

    initial begin
        int t, p;
        vec_t rv;
        tbl[0] = '{lat: 2, duty: 100, restart: 1'b0, exp_words: NWORDS, exp_frames: NFR};
        tbl[1] = '{lat: 2, duty: 30,  restart: 1'b1, exp_words: NWORDS, exp_frames: NFR};
        tbl[2] = '{lat: 1, duty: 100, restart: 1'b1, exp_words: NWORDS, exp_frames: NFR};
        tbl[3] = '{lat: 3, duty: 100, restart: 1'b0, exp_words: NWORDS, exp_frames: NFR};
        tbl[4] = '{lat: 3, duty: 30,  restart: 1'b0, exp_words: NWORDS, exp_frames: NFR};
        rv = '{lat: 2, duty: 100, restart: 1'b0, exp_words: NWORDS, exp_frames: NFR};
        reset_n = 1'b0;
        start = 1'b0;
        readable = 1'b0;
        m_clr = 1'b1;
        exp_seq = '0;
        tick(3);
        check("rst_rd_en", {31'b0, rd_en}, 0);
        check("rst_valid", {31'b0, out_valid}, 0);
        check("rst_sof", {31'b0, out_sof}, 0);
        check("rst_eof", {31'b0, out_eof}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_seq", {16'b0, seq}, 0);
        reset_n = 1'b1;
        tick();
        m_clr = 1'b0;

        p = rd_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(5);
        check("unreadable_busy", {31'b0, busy}, 0);
        check("unreadable_reads", rd_cnt - p, 0);
        check("unreadable_seq", {16'b0, seq}, 0);

        for (int i = 0; i < 5; i++) run_bank(tbl[i]);

        lat = 3;
        m_clr = 1'b1;
        tick();
        m_clr = 1'b0;
        gen_exp(exp_seq);
        p = pay_pops;
        start = 1'b1;
        readable = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (pay_pops - p < 10 && t < 500) begin
            tick();
            t++;
        end
        check("reached_10_words", {31'b0, t < 500}, 1);
        check("dv_in_flight", {31'b0, |dv_sr}, 1);
        reset_n = 1'b0;
        tick();
        check("mid_rst_rd_en", {31'b0, rd_en}, 0);
        check("mid_rst_valid", {31'b0, out_valid}, 0);
        check("mid_rst_sof", {31'b0, out_sof}, 0);
        check("mid_rst_eof", {31'b0, out_eof}, 0);
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_seq", {16'b0, seq}, 0);
        reset_n = 1'b1;
        exp_q.delete();
        exp_seq = '0;
        tick(6);
        check("late_dv_dropped", {31'b0, out_valid}, 0);
        check("late_dv_busy", {31'b0, busy}, 0);
        run_bank(rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
